// File: rtl/insn_encoder_pkg.sv
// Shared constants and types for the RV32I field-to-word encoder.
// Opcodes, the canonical NOP, FSM states and the decoded-field bundle.
package insn_encoder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_fields_t;

    // True when v, read as two's complement, fits in a signed field of `bits`.
    function automatic logic fits_signed(input logic [31:0] v,
                                         input int unsigned bits);
        logic signed [31:0] s;
        logic signed [31:0] lim;
        s   = signed'(v);
        lim = 32'sd1 <<< (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write bus.
// master drives fields and wr_ready_i; slave is the encoder.
interface insn_encoder_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              valid_i;
    logic              ready_o;
    logic              last_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [DWIDTH-1:0] imm_i;
    logic              wr_en_o;
    logic              wr_ready_i;
    logic [AWIDTH-1:0] wr_addr_o;
    logic [DWIDTH-1:0] wr_data_o;

    modport master (
        output valid_i, last_i, opcode_i, rd_i, rs1_i, rs2_i,
        output funct3_i, funct7_i, imm_i, wr_ready_i,
        input  ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  valid_i, last_i, opcode_i, rd_i, rs1_i, rs2_i,
        input  funct3_i, funct7_i, imm_i, wr_ready_i,
        output ready_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/insn_encoder_pack.sv
// Combinational packer: decoded fields -> RV32I word with range/legality flags.
// Out-of-range immediates are still packed with their truncated bits.
module insn_pack
    import insn_encoder_pkg::*;
(
    input  enc_fields_t i_fields,
    output logic [31:0] o_word,
    output logic        o_range_err,
    output logic        o_illegal
);

    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;

    assign w_op  = i_fields.opcode;
    assign w_rd  = i_fields.rd;
    assign w_rs1 = i_fields.rs1;
    assign w_rs2 = i_fields.rs2;
    assign w_f3  = i_fields.funct3;
    assign w_f7  = i_fields.funct7;
    assign w_imm = i_fields.imm;

    // Select the format by opcode; unknown opcodes fall back to NOP.
    always_comb begin
        o_word      = NOP_INSN;
        o_range_err = 1'b0;
        o_illegal   = 1'b0;
        unique case (w_op)
            OP_R: begin
                o_word = {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_op};
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                if (w_op == OP_IMM && (w_f3 == 3'b001 || w_f3 == 3'b101))
                    o_word = {w_f7, w_imm[4:0], w_rs1, w_f3, w_rd, w_op};
                else
                    o_word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
                o_range_err = !fits_signed(w_imm, 12);
            end
            OP_STORE: begin
                o_word = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], w_op};
                o_range_err = !fits_signed(w_imm, 12);
            end
            OP_BRANCH: begin
                o_word = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3,
                          w_imm[4:1], w_imm[11], w_op};
                o_range_err = !fits_signed(w_imm, 13) || w_imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                o_word = {w_imm[31:12], w_rd, w_op};
                o_range_err = (w_imm[11:0] != 12'h000);
            end
            OP_JAL: begin
                o_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                          w_rd, w_op};
                o_range_err = !fits_signed(w_imm, 21) || w_imm[0];
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// RV32I encoder top: start/run/done FSM, 2-entry word FIFO,
// and sequential write addressing into instruction memory.
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    insn_encoder_if.slave     bus,
    output logic [AWIDTH-1:0] count_o,
    output logic              done_o,
    output logic              err_o
);

    enc_state_e        r_state;
    enc_state_e        w_state_n;
    logic              r_ready;
    logic              w_ready_n;
    logic              r_last;
    logic              w_last_n;
    logic [DWIDTH-1:0] r_mem [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_occ;
    logic [1:0]        w_occ_n;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_count;
    logic              r_err;
    enc_fields_t       w_fields;
    logic [31:0]       w_word;
    logic              w_range_err;
    logic              w_illegal;
    logic              w_push;
    logic              w_pop;
    logic              w_start;

    assign w_fields = '{
        opcode: bus.opcode_i,
        rd:     bus.rd_i,
        rs1:    bus.rs1_i,
        rs2:    bus.rs2_i,
        funct3: bus.funct3_i,
        funct7: bus.funct7_i,
        imm:    bus.imm_i
    };

    insn_pack u_pack (
        .i_fields    (w_fields),
        .o_word      (w_word),
        .o_range_err (w_range_err),
        .o_illegal   (w_illegal)
    );

    assign w_start = (r_state == IDLE) & start_i;
    assign w_push  = bus.valid_i & r_ready;
    assign w_pop   = (r_occ != 2'd0) & bus.wr_ready_i;
    assign w_occ_n = r_occ + {1'b0, w_push} - {1'b0, w_pop};

    // Next state, last-seen flag and the registered ready for next cycle.
    always_comb begin
        w_state_n = r_state;
        w_last_n  = r_last;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_n = RUN;
                    w_last_n  = 1'b0;
                end
            end
            RUN: begin
                if (w_push && bus.last_i)
                    w_last_n = 1'b1;
                if (r_last && r_occ == 2'd0)
                    w_state_n = DONE;
            end
            DONE: begin
                w_state_n = IDLE;
                w_last_n  = 1'b0;
            end
            default: begin
                w_state_n = IDLE;
                w_last_n  = 1'b0;
            end
        endcase
        w_ready_n = (w_state_n == RUN) & (w_occ_n != 2'd2) & !w_last_n;
    end

    // State register with ready/last-seen flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ready <= w_ready_n;
            r_last  <= w_last_n;
        end
    end

    // Two-entry word FIFO between the packer and the memory port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_word;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_occ <= w_occ_n;
        end
    end

    // Write address, word count and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_addr  <= base_addr_i;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr  <= r_addr + AWIDTH'(4);
                r_count <= r_count + AWIDTH'(1);
            end
            if (w_push && (w_range_err || w_illegal))
                r_err <= 1'b1;
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.wr_en_o   = (r_occ != 2'd0);
    assign bus.wr_addr_o = r_addr;
    assign bus.wr_data_o = r_mem[r_rp];
    assign count_o       = r_count;
    assign done_o        = (r_state == DONE);
    assign err_o         = r_err;

endmodule

// File: tb/tb_insn_encoder.sv
// Bench for insn_encoder: directed programs plus randomized bundles,
// scored against an arithmetic reference encoder and address model.
module tb_insn_encoder;
    import insn_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] count_o;
    logic        done_o;
    logic        err_o;
    int          rdy_mode = 1;

    insn_encoder_if bus ();

    insn_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .bus         (bus.slave),
        .count_o     (count_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit fits(input longint s, input int n);
        longint lim;
        lim = longint'(1) << (n - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Reference encoder: place each field by weight, not by bit slicing.
    function automatic logic [31:0] ref_enc(
        input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm, output bit bad);
        longint unsigned lop, lrd, lrs1, lrs2, lf3, lf7, u, w, b;
        longint s;
        localparam longint unsigned P20 = 64'd1 << 20;
        localparam longint unsigned P21 = 64'd1 << 21;
        localparam longint unsigned P25 = 64'd1 << 25;
        localparam longint unsigned P31 = 64'd1 << 31;
        lop = 64'(op); lrd = 64'(rd); lrs1 = 64'(rs1);
        lrs2 = 64'(rs2); lf3 = 64'(f3); lf7 = 64'(f7);
        u = 64'(imm);
        s = longint'(signed'(imm));
        bad = 1'b0;
        b = lop + lrd * 128 + lf3 * 4096 + lrs1 * 32768;
        case (op)
            7'b0110011: w = b + lrs2 * P20 + lf7 * P25;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5))
                    w = b + (u % 32) * P20 + lf7 * P25;
                else
                    w = b + (u % 4096) * P20;
                bad = !fits(s, 12);
            end
            7'b0100011: begin
                w = lop + (u % 32) * 128 + lf3 * 4096 + lrs1 * 32768 +
                    lrs2 * P20 + ((u / 32) % 128) * P25;
                bad = !fits(s, 12);
            end
            7'b1100011: begin
                w = lop + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 +
                    lf3 * 4096 + lrs1 * 32768 + lrs2 * P20 +
                    ((u / 32) % 64) * P25 + ((u / 4096) % 2) * P31;
                bad = !fits(s, 13) || (u % 2 != 0);
            end
            7'b0110111, 7'b0010111: begin
                w = (u / 4096) * 4096 + lrd * 128 + lop;
                bad = (u % 4096 != 0);
            end
            7'b1101111: begin
                w = lop + lrd * 128 + ((u / 4096) % 256) * 4096 +
                    ((u / 2048) % 2) * P20 + ((u / 2) % 1024) * P21 +
                    ((u / P20) % 2) * P31;
                bad = !fits(s, 21) || (u % 2 != 0);
            end
            default: begin
                w = 64'h13;
                bad = 1'b1;
            end
        endcase
        return w[31:0];
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_words = '0;
    logic        exp_err   = 1'b0;
    int          wr_seen   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a, prev_d;

    // Write-ready driver: 0 = hold low, 1 = hold high, else random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.wr_ready_i = 1'b0;
            1:       bus.wr_ready_i = 1'b1;
            default: bus.wr_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard: sample mid-cycle, predict pushes, check pops.
    always @(negedge clk) begin
        bit          bad;
        logic [31:0] w;
        if (!rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (start_i) begin
                exp_addr  = base_addr_i;
                exp_words = '0;
                exp_err   = 1'b0;
                log_a.delete();
                log_d.delete();
            end
            if (prev_stall) begin
                check("hold_en", bus.wr_en_o, 1'b1);
                check("hold_addr", bus.wr_addr_o, prev_a);
                check("hold_data", bus.wr_data_o, prev_d);
            end
            if (bus.wr_en_o && bus.wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr", bus.wr_en_o, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr_o, exp_addr);
                    check("wr_data", bus.wr_data_o, w);
                    exp_addr = exp_addr + 32'd4;
                end
                log_a.push_back(bus.wr_addr_o);
                log_d.push_back(bus.wr_data_o);
                wr_seen++;
            end
            if (bus.valid_i && bus.ready_o) begin
                w = ref_enc(bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                            bus.funct3_i, bus.funct7_i, bus.imm_i, bad);
                exp_q.push_back(w);
                exp_err   = exp_err | bad;
                exp_words = exp_words + 32'd1;
            end
            prev_stall = bus.wr_en_o & !bus.wr_ready_i;
            prev_a     = bus.wr_addr_o;
            prev_d     = bus.wr_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        step();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        int k;
        bus.opcode_i = op;  bus.rd_i = rd;   bus.rs1_i = rs1;
        bus.rs2_i = rs2;    bus.funct3_i = f3; bus.funct7_i = f7;
        bus.imm_i = imm;    bus.last_i = last; bus.valid_i = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.ready_o) break;
        end
        if (k == 200) check("send_timeout", bus.ready_o, 1'b1);
        step();
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done_o) break;
        end
        check("done", done_o, 1'b1);
        step();
        check("done_pulse", done_o, 1'b0);
        check("count", count_o, exp_words);
        check("drained", exp_q.size(), 0);
        check("err", err_o, exp_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, bus.ready_o, 1'b0);
        check({tag, "_wren"}, bus.wr_en_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_addr"}, bus.wr_addr_o, 32'h0);
        check({tag, "_data"}, bus.wr_data_o, 32'h0);
        check({tag, "_count"}, count_o, 32'h0);
    endtask

    task automatic send_rand(input logic last);
        logic [6:0]  ops [11];
        logic [31:0] imm, tmp;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        tmp = $urandom;
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            default: imm = {tmp[31:12], 12'h000};
        endcase
        send(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom),
             5'($urandom), 3'($urandom), 7'($urandom), imm, last);
    endtask

    initial begin
        int w0;
        bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.opcode_i = '0;
        bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;

        #12;
        check_zero("rst");
        step();
        rst = 1'b1;
        step();

        start(32'h100);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done();
        check("addi_n", log_d.size(), 1);
        check("addi_data", log_d[0], 32'h00500093);
        check("addi_addr", log_a[0], 32'h100);

        start(32'h100);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        wait_done();
        check("b2b_n", log_d.size(), 3);
        check("b2b_d0", log_d[0], 32'h002081B3);
        check("b2b_d1", log_d[1], 32'hFE208EE3);
        check("b2b_d2", log_d[2], 32'h123452B7);
        check("b2b_a2", log_a[2], 32'h108);

        start(32'h300);
        rdy_mode = 0;
        step();
        step();
        send(7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0);
        send(7'h33, 5'd4, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0);
        @(negedge clk);
        check("stall_ready", bus.ready_o, 1'b0);
        check("stall_wren", bus.wr_en_o, 1'b1);
        repeat (3) @(negedge clk);
        rdy_mode = 1;
        send(7'h23, 5'd0, 5'd2, 5'd4, 3'd2, 7'd0, 32'hFFFFFFF8, 1'b1);
        wait_done();
        check("stall_n", log_d.size(), 3);
        check("stall_a1", log_a[1], 32'h304);

        start(32'h400);
        send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b1);
        wait_done();
        check("ill_d0", log_d[0], 32'h00000013);
        check("ill_d1", log_d[1], 32'h80000093);
        check("ill_err", err_o, 1'b1);
        repeat (5) step();
        check("ill_sticky", err_o, 1'b1);

        start(32'hFFFFFFFC);
        check("start_clr_err", err_o, 1'b0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        send(7'h17, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b1);
        wait_done();
        check("wrap_a0", log_a[0], 32'hFFFFFFFC);
        check("wrap_a1", log_a[1], 32'h00000000);

        rdy_mode = 2;
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(2, 6);
            start(32'($urandom) & ~32'd3);
            for (int i = 0; i < n; i++) begin
                send_rand(i == n - 1);
                repeat ($urandom_range(0, 2)) step();
            end
            wait_done();
        end

        start(32'h200);
        rdy_mode = 0;
        step();
        step();
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        rdy_mode = 1;
        step();
        step();
        rst = 1'b1;
        w0 = wr_seen;
        repeat (10) step();
        check("midrst_nowr", wr_seen, w0);
        check("midrst_idle", bus.wr_en_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
